// File: rtl/tlb_ptw_pkg.sv
// tlb_ptw_pkg: PTE bit positions, walker states and PTE address helper
package tlb_ptw_pkg;
  localparam int PTE_V = 0;
  localparam int PTE_R = 1;
  localparam int PTE_W = 2;
  typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP} state_t;
  function automatic logic [31:0] pte_addr(input logic [19:0] ppn, input logic [9:0] idx);
    return {ppn, idx, 2'b00};
  endfunction
endpackage

// File: rtl/tlb_ptw_pte_decode.sv
// tlb_ptw_pte_decode: classifies a PTE word and folds level-1 leaves into 4 KiB PTEs
module tlb_ptw_pte_decode import tlb_ptw_pkg::*; (
  input  logic [31:0] pte,
  input  logic        lvl1,
  input  logic [9:0]  vpn0,
  output logic        is_invalid,
  output logic        is_pointer,
  output logic        is_leaf,
  output logic [31:0] folded_pte
);
  assign is_invalid = !pte[PTE_V];
  assign is_leaf    = pte[PTE_V] & (pte[PTE_R] | pte[PTE_W]);
  assign is_pointer = pte[PTE_V] & !(pte[PTE_R] | pte[PTE_W]);
  assign folded_pte = lvl1 & is_leaf ? {pte[31:22], vpn0, pte[11:0]} : pte;
endmodule

// File: rtl/tlb_ptw.sv
// tlb_ptw: two-level page-table walker between the TLB miss channel and a memory read port
module tlb_ptw import tlb_ptw_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] satp_ppn_i,
  input  logic        ptw_req_valid_i,
  output logic        ptw_req_ready_o,
  input  logic [31:0] ptw_vaddr_i,
  output logic        ptw_resp_valid_o,
  input  logic        ptw_resp_ready_i,
  output logic [31:0] ptw_pte_o,
  output logic        mem_req_valid_o,
  input  logic        mem_req_ready_i,
  output logic [31:0] mem_addr_o,
  input  logic        mem_resp_valid_i,
  output logic        mem_resp_ready_o,
  input  logic [31:0] mem_rdata_i
);
  localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);
  state_t state, state_n;
  logic [19:0] ppn, vpn;
  logic [31:0] result, folded, res_d;
  logic [15:0] cnt;
  logic alive, in_wait, resp_hit, timeout, is_invalid, is_pointer, is_leaf, unused_va;
  assign unused_va = ^ptw_vaddr_i[11:0];
  assign in_wait   = state == L1_WAIT || state == L0_WAIT;
  assign resp_hit  = in_wait & mem_resp_valid_i;
  assign timeout   = in_wait & !mem_resp_valid_i & (cnt == TLIM);
  assign res_d     = is_invalid | is_leaf ? folded : 32'h0;
  assign mem_addr_o = pte_addr(ppn, state == L1_REQ ? vpn[19:10] : vpn[9:0]);
  assign ptw_pte_o  = result;
  tlb_ptw_pte_decode u_dec (
    .pte        (mem_rdata_i),
    .lvl1       (state == L1_WAIT),
    .vpn0       (vpn[9:0]),
    .is_invalid (is_invalid),
    .is_pointer (is_pointer),
    .is_leaf    (is_leaf),
    .folded_pte (folded)
  );
  always_ff @(posedge clk)
    if (!rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    ptw_req_ready_o = 1'b0;
    mem_req_valid_o = 1'b0;
    mem_resp_ready_o = 1'b0;
    ptw_resp_valid_o = 1'b0;
    unique case (state)
      IDLE: begin
        ptw_req_ready_o = alive;
        if (alive && ptw_req_valid_i) state_n = L1_REQ;
      end
      L1_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_n = L1_WAIT;
      end
      L1_WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (resp_hit) state_n = is_pointer ? L0_REQ : RESP;
        else if (timeout) state_n = RESP;
      end
      L0_REQ: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) state_n = L0_WAIT;
      end
      L0_WAIT: begin
        mem_resp_ready_o = 1'b1;
        if (resp_hit || timeout) state_n = RESP;
      end
      RESP: begin
        ptw_resp_valid_o = 1'b1;
        if (ptw_resp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // alive keeps the request port closed during the reset cycle itself
  always_ff @(posedge clk)
    if (!rst) begin
      alive  <= 1'b0;
      ppn    <= '0;
      vpn    <= '0;
      result <= '0;
      cnt    <= '0;
    end else begin
      alive <= 1'b1;
      if (ptw_req_ready_o && ptw_req_valid_i) begin
        ppn <= satp_ppn_i;
        vpn <= ptw_vaddr_i[31:12];
      end
      if (state == L1_WAIT && resp_hit && is_pointer) ppn <= mem_rdata_i[31:12];
      if (resp_hit) result <= res_d;
      else if (timeout) result <= '0;
      cnt <= in_wait ? cnt + 16'd1 : '0;
    end
endmodule

// File: tb/tb_tlb_ptw.sv
// tb_tlb_ptw: directed walks against a page-table model with a per-cycle output checker
module tb_tlb_ptw;
  logic clk = 0, rst = 0;
  logic [19:0] satp_ppn_i = '0;
  logic ptw_req_valid_i = 0, ptw_resp_ready_i = 0, mem_req_ready_i = 0, mem_resp_valid_i = 0;
  logic [31:0] ptw_vaddr_i = '0, mem_rdata_i = '0;
  logic ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o;
  logic [31:0] ptw_pte_o, mem_addr_o;
  always #5 clk = ~clk;
  tlb_ptw #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .satp_ppn_i(satp_ppn_i),
    .ptw_req_valid_i(ptw_req_valid_i), .ptw_req_ready_o(ptw_req_ready_o), .ptw_vaddr_i(ptw_vaddr_i),
    .ptw_resp_valid_o(ptw_resp_valid_o), .ptw_resp_ready_i(ptw_resp_ready_i), .ptw_pte_o(ptw_pte_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o), .mem_rdata_i(mem_rdata_i)
  );
  int checks = 0, errors = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_pte = '0, ea0 = '0, ea1 = '0, addr_q = '0;
  int en = 0, nreads = 0, resp_cnt = 0, stall = 0, inject = 0, drop_at = 0;
  bit req_fire = 0, resp_fire = 0, inj_on = 0;
  logic prev_rst = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction
  // translation computed from page-table rules with plain arithmetic
  task automatic model(input logic [19:0] root, input logic [31:0] va, input bit noresp);
    logic [31:0] w1, w0;
    ea0 = {root, 12'h000} + (va >> 22) * 4;
    ea1 = '0;
    en = 1;
    if (noresp) exp_pte = '0;
    else begin
      w1 = rd(ea0);
      if (!w1[0]) exp_pte = w1;
      else if (w1[1] || w1[2]) exp_pte = (w1 & 32'hFFC0_0FFF) | (va & 32'h003F_F000);
      else begin
        ea1 = ((w1 >> 12) << 12) + ((va >> 12) & 32'h3FF) * 4;
        w0 = rd(ea1);
        en = 2;
        exp_pte = (!w0[0] || w0[1] || w0[2]) ? w0 : 32'h0;
      end
    end
  endtask
  // memory: one cycle response latency, optional request stall, dropped read, late injection
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      mem_resp_valid_i = 0; mem_req_ready_i = 0;
      req_fire = 0; resp_fire = 0; inj_on = 0; inject = 0; stall = 0;
    end else begin
      if (resp_fire || inj_on) mem_resp_valid_i = 0;
      inj_on = 0;
      if (req_fire) begin
        nreads++;
        if (nreads != drop_at) begin mem_resp_valid_i = 1; mem_rdata_i = rd(addr_q); end
      end
      if (inject > 0) begin inject--; inj_on = 1; mem_resp_valid_i = 1; mem_rdata_i = 32'hFFFF_FFFF; end
      mem_req_ready_i = (stall == 0);
      if (mem_req_valid_o && stall > 0) stall--;
      req_fire = mem_req_valid_o && mem_req_ready_i;
      addr_q = mem_addr_o;
      resp_fire = mem_resp_valid_i && mem_resp_ready_o;
    end
  end
  initial forever begin
    @(negedge clk); #1;
    if (!prev_rst) begin
      chk("rst_ctrl", {ptw_req_ready_o, mem_req_valid_o, mem_resp_ready_o, ptw_resp_valid_o}, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_pte", ptw_pte_o, 0);
    end
    if (ptw_resp_valid_o) chk("pte", ptw_pte_o, exp_pte);
    if (ptw_resp_valid_o && ptw_resp_ready_i) resp_cnt++;
    if (mem_req_valid_o) chk("mem_addr", mem_addr_o, nreads == 0 ? ea0 : ea1);
    if (ptw_req_ready_o || ptw_resp_valid_o || mem_req_valid_o) chk("resp_ready_outside_wait", 32'(mem_resp_ready_o), 0);
    prev_rst = rst;
  end
  task automatic issue(input logic [19:0] root, input logic [31:0] va, input bit noresp);
    model(root, va, noresp);
    nreads = 0; resp_cnt = 0;
    satp_ppn_i = root; ptw_vaddr_i = va; ptw_req_valid_i = 1;
    for (int t = 0; t < 20 && !ptw_req_ready_o; t++) @(negedge clk);
    chk("req_ready", 32'(ptw_req_ready_o), 1);
    @(negedge clk);
    ptw_req_valid_i = 0; satp_ppn_i = '1; ptw_vaddr_i = '1;
  endtask
  task automatic walk(input logic [19:0] root, input logic [31:0] va, input logic [31:0] lit,
                      input int lat, input int rs, input bit inj);
    int c;
    issue(root, va, drop_at == 1);
    c = 1;
    while (!ptw_resp_valid_o && c < 60) begin @(negedge clk); c++; end
    chk("resp_seen", 32'(ptw_resp_valid_o), 1);
    if (lat > 0) chk("latency", c, lat);
    for (int i = 0; i < rs; i++) begin
      if (inj && i == 0) inject = 3;
      @(negedge clk);
      chk("resp_held", 32'(ptw_resp_valid_o), 1);
    end
    chk("pte_lit", ptw_pte_o, lit);
    ptw_resp_ready_i = 1;
    @(negedge clk);
    ptw_resp_ready_i = 0;
    chk("resp_once", resp_cnt, 1);
    chk("reads", nreads, en);
    chk("idle_after", {ptw_resp_valid_o, ptw_req_ready_o}, 2'b01);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    mem[32'h0001_0004] = 32'h0002_0001;
    mem[32'h0002_000C] = 32'h1234_5007;
    mem[32'h0001_1004] = 32'h8040_0003;
    mem[32'h0001_2004] = 32'h0000_0000;
    mem[32'h0001_3004] = 32'h0003_0001;
    mem[32'h0003_000C] = 32'h0003_0001;
    mem[32'h0001_4FFC] = 32'h0000_0005;
    repeat (2) @(negedge clk);
    chk("reset_req_ready", 32'(ptw_req_ready_o), 0);
    rst = 1;
    @(negedge clk);
    chk("ready_after_release", 32'(ptw_req_ready_o), 1);
    walk(20'h00010, 32'h0040_3ABC, 32'h1234_5007, 5, 0, 0);
    walk(20'h00011, 32'h0040_3ABC, 32'h8040_3003, 3, 0, 0);
    walk(20'h00012, 32'h0040_3ABC, 32'h0000_0000, 3, 0, 0);
    walk(20'h00013, 32'h0040_3ABC, 32'h0000_0000, 5, 0, 0);
    walk(20'h00014, 32'hFFFF_F123, 32'h003F_F005, 3, 0, 0);
    stall = 4;
    walk(20'h00010, 32'h0040_3ABC, 32'h1234_5007, 0, 3, 0);
    drop_at = 1;
    walk(20'h00015, 32'h0040_3ABC, 32'h0000_0000, 10, 2, 1);
    drop_at = 0;
    walk(20'h00010, 32'h0040_3ABC, 32'h1234_5007, 5, 0, 0);
    drop_at = 2;
    issue(20'h00010, 32'h0040_3ABC, 0);
    for (int t = 0; t < 20 && !(nreads == 2 && mem_resp_ready_o); t++) @(negedge clk);
    chk("in_l0_wait", {30'(nreads), mem_resp_ready_o}, {30'd2, 1'b1});
    rst = 0;
    @(negedge clk);
    chk("midwalk_reset_ready", 32'(ptw_req_ready_o), 0);
    @(negedge clk);
    rst = 1; drop_at = 0; nreads = 0;
    @(negedge clk);
    chk("ready_after_midwalk_reset", 32'(ptw_req_ready_o), 1);
    walk(20'h00011, 32'h0040_3ABC, 32'h8040_3003, 3, 0, 0);
    walk(20'h00010, 32'h0040_3ABC, 32'h1234_5007, 5, 1, 0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tlb_ptw.md
# tlb_ptw

Two-level page-table walker serving TLB misses; sits directly downstream of the TLB on its PTW request/response channel and upstream of the memory port. Accepts a virtual address and walks a 32-bit two-level table rooted at `satp_ppn_i`, issuing one word read per level. Returns a single 4 KiB-granular PTE in the format the TLB consumes: [31:12] PPN, bit 0 V, bit 1 R, bit 2 W. Megapage leaves are folded into 4 KiB PTEs before return.

## Interface
- `TIMEOUT_CYCLES`, 255: max cycles spent in a memory-wait state before the walk aborts (1..65535).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `satp_ppn_i`  in  20  root table PPN; sampled on request accept.
- `ptw_req_valid_i`  in  1  walk request from TLB.
- `ptw_req_ready_o`  out  1  walker idle, can accept.
- `ptw_vaddr_i`  in  32  virtual address to translate.
- `ptw_resp_valid_o`  out  1  PTE result valid.
- `ptw_resp_ready_i`  in  1  TLB accepts result.
- `ptw_pte_o`  out  32  returned PTE.
- `mem_req_valid_o`  out  1  memory read request.
- `mem_req_ready_i`  in  1  memory accepts request.
- `mem_addr_o`  out  32  byte address of PTE word.
- `mem_resp_valid_i`  in  1  read data valid.
- `mem_resp_ready_o`  out  1  walker accepts read data.
- `mem_rdata_i`  in  32  PTE word read.

## Operation
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP. Reset state IDLE.
- IDLE: `ptw_req_ready_o`=1. On valid&ready latch vaddr and `satp_ppn_i`, go L1_REQ.
- L1_REQ: `mem_req_valid_o`=1, `mem_addr_o`={root_ppn, vaddr[31:22], 2'b00}; held stable until `mem_req_ready_i`, then L1_WAIT.
- L1_WAIT: `mem_resp_ready_o`=1; on response decode PTE:
  - V=0 -> result = raw PTE (V=0), go RESP.
  - V=1, R=W=0 -> pointer; latch PPN, go L0_REQ.
  - V=1, R|W -> megapage leaf; result = {pte[31:22], vaddr[21:12], pte[11:0]}, go RESP.
- L0_REQ: as L1_REQ with `mem_addr_o`={pte1_ppn, vaddr[21:12], 2'b00}.
- L0_WAIT: on response: V=0 or R|W -> result = raw PTE; V=1 with R=W=0 (pointer at last level) -> result = 32'h0. Go RESP.
- RESP: `ptw_resp_valid_o`=1, `ptw_pte_o` stable until `ptw_resp_ready_i`, then IDLE.
- Timeout: counter clears on entering a WAIT state and increments each WAIT cycle without response; on reaching `TIMEOUT_CYCLES`, result = 32'h0, go RESP. Any later memory response is not accepted (`mem_resp_ready_o`=0 outside WAIT); the memory side must drop it.
- Address arithmetic is pure concatenation; no carries, no overflow.

## Timing
- Reset (rst=0): all outputs 0, including `ptw_req_ready_o`; first cycle after release `ptw_req_ready_o`=1.
- Reset mid-walk: abort immediately to IDLE, no response; memory shares the same reset.
- Zero-wait memory (req_ready=1, response one cycle after request accept): accept at cycle 0 -> `ptw_resp_valid_o` at cycle 5 (two-level), cycle 3 (megapage or level-1 invalid).
- At most one walk and one memory request outstanding; no request issued while in a WAIT state.
- `ptw_req_ready_o`, `mem_req_valid_o`, `mem_resp_ready_o`, `ptw_resp_valid_o` are decoded from registered state only; no input-to-output combinational path.
- New request is accepted no earlier than the cycle after the RESP handshake.

## Structure
- Shared `tlb_params.vh`: PTE bit positions (PTE_V=0, PTE_R=1, PTE_W=2, PPN [31:12]), PTW state encodings, VPN1/VPN0 field ranges.
- One combinational sub-module `ptw_pte_decode`: PTE + level + vaddr -> {is_invalid, is_pointer, is_leaf, folded_pte}.
- Top module holds FSM, address/PTE registers, timeout counter.

## Test plan
- Root 0x00010, vaddr 0x0040_3ABC; L1 word @0x0001_0004 = 0x0002_0001, L0 word @0x0002_000C = 0x1234_5007 -> `ptw_pte_o`=0x1234_5007, valid at cycle 5.
- L1 word = 0x8040_0003 (megapage R), vaddr 0x0040_3ABC -> `ptw_pte_o`=0x8040_3003 at cycle 3, single memory read.
- L1 word = 0x0000_0000 -> `ptw_pte_o`=0x0 after one read; L0 word = 0x0003_0001 (pointer at last level) -> `ptw_pte_o`=0x0.
- `mem_req_ready_i` low 4 cycles, `ptw_resp_ready_i` low 3 cycles -> `mem_addr_o` and `ptw_pte_o` stable throughout; correct PTE delivered once.
- TIMEOUT_CYCLES=8, memory never responds -> `ptw_pte_o`=0x0 valid after 8 wait cycles; late response ignored, next walk correct.
- rst=0 asserted during L0_WAIT -> all outputs 0 next cycle, `ptw_req_ready_o`=1 after release, fresh walk correct.
